// File: rtl/gb_xact_pkg.sv
// Shared types and constants for the ghostbus transaction engine.
package gb_xact_pkg;

  typedef enum logic [2:0] {IDLE, WR, RD, WAIT, RSP} state_t;

  // Legal read-delay range; the delay counter is sized for the maximum.
  localparam int unsigned RD_DLY_MIN = 1;
  localparam int unsigned RD_DLY_MAX = 15;
  localparam int unsigned RD_DLY_W   = $clog2(RD_DLY_MAX + 1);

  function automatic bit rd_dly_ok(input int unsigned d);
    return (d >= RD_DLY_MIN) && (d <= RD_DLY_MAX);
  endfunction

endpackage

// File: rtl/gb_sat_counter.sv
// Event counter with synchronous clear and optional saturation.
module gb_sat_counter #(
  parameter int W   = 16,
  parameter bit SAT = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // clear has priority over increment; saturating flavour sticks at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        cnt <= '0;
    else if (clr)                      cnt <= '0;
    else if (inc && !(SAT && (&cnt)))  cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/gb_xact_engine.sv
// Ghostbus transaction master: write/read bursts, fixed read latency,
// optional masked compare of read data, error and beat counters.
module gb_xact_engine
  import gb_xact_pkg::*;
#(
  parameter int ADW        = 24,
  parameter int DW         = 32,
  parameter int READ_DELAY = 3,
  parameter int BW         = 8,
  parameter int CW         = 16
) (
  input  logic           gb_clk,
  input  logic           gb_rst_n,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic           cmd_write,
  input  logic [ADW-1:0] cmd_addr,
  input  logic [DW-1:0]  cmd_wdata,
  input  logic [DW-1:0]  cmd_expect,
  input  logic [DW-1:0]  cmd_mask,
  input  logic           cmd_check,
  input  logic [BW-1:0]  cmd_len,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [DW-1:0]  rsp_rdata,
  output logic [ADW-1:0] rsp_addr,
  output logic           rsp_err,
  output logic [ADW-1:0] gb_addr,
  output logic [DW-1:0]  gb_wdata,
  output logic           gb_wen,
  output logic           gb_rstb,
  input  logic [DW-1:0]  gb_rdata,
  input  logic           clr,
  output logic           busy,
  output logic           fail,
  output logic [CW-1:0]  err_count,
  output logic [CW-1:0]  xact_count
);

  if (!rd_dly_ok(READ_DELAY)) begin : g_bad_delay
    $error("gb_xact_engine: READ_DELAY out of range 1..15");
  end

  state_t state, nxt;

  logic [ADW-1:0]      addr_q;
  logic [DW-1:0]       wdata_q, expect_q, mask_q;
  logic                check_q;
  logic [BW-1:0]       len_q, k_q, k_nxt;
  logic [RD_DLY_W-1:0] dly_q;
  logic                load, k_inc, last, hs_rsp, cap;
  logic [ADW-1:0]      a_base;
  logic [DW-1:0]       d_base;

  assign last      = (k_q == len_q);
  assign hs_rsp    = (state == RSP) && rsp_ready;
  assign cap       = (state == WAIT) && (dly_q == RD_DLY_W'(1));
  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign rsp_valid = (state == RSP);

  // beat index and base values the bus registers will use next cycle
  assign k_nxt  = load ? '0 : (k_inc ? k_q + BW'(1) : k_q);
  assign a_base = load ? cmd_addr  : addr_q;
  assign d_base = load ? cmd_wdata : wdata_q;

  // state register
  always_ff @(posedge gb_clk or negedge gb_rst_n) begin
    if (!gb_rst_n) state <= IDLE;
    else           state <= nxt;
  end

  // next-state and beat sequencing
  always_comb begin
    nxt   = state;
    load  = 1'b0;
    k_inc = 1'b0;
    unique case (state)
      IDLE: if (cmd_valid) begin
        load = 1'b1;
        nxt  = cmd_write ? WR : RD;
      end
      WR:   if (last) nxt = IDLE; else k_inc = 1'b1;
      RD:   nxt = WAIT;
      WAIT: if (cap) nxt = RSP;
      RSP:  if (rsp_ready) begin
        if (last) nxt = IDLE;
        else begin
          k_inc = 1'b1;
          nxt   = RD;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  // command latch and beat index
  always_ff @(posedge gb_clk or negedge gb_rst_n) begin
    if (!gb_rst_n) begin
      addr_q <= '0; wdata_q <= '0; expect_q <= '0; mask_q <= '0;
      check_q <= 1'b0; len_q <= '0; k_q <= '0;
    end else begin
      k_q <= k_nxt;
      if (load) begin
        addr_q   <= cmd_addr;
        wdata_q  <= cmd_wdata;
        expect_q <= cmd_expect;
        mask_q   <= cmd_mask;
        check_q  <= cmd_check;
        len_q    <= cmd_len;
      end
    end
  end

  // registered bus drive; strobes follow the state they belong to
  always_ff @(posedge gb_clk or negedge gb_rst_n) begin
    if (!gb_rst_n) begin
      gb_addr <= '0; gb_wdata <= '0; gb_wen <= 1'b0; gb_rstb <= 1'b0;
    end else begin
      gb_wen  <= (nxt == WR);
      gb_rstb <= (nxt == RD);
      if (nxt == WR || nxt == RD) gb_addr  <= a_base + ADW'(k_nxt);
      if (nxt == WR)              gb_wdata <= d_base + DW'(k_nxt);
    end
  end

  // read latency counter: loaded on the strobe, counts down through WAIT
  always_ff @(posedge gb_clk or negedge gb_rst_n) begin
    if (!gb_rst_n)            dly_q <= '0;
    else if (state == RD)     dly_q <= RD_DLY_W'(READ_DELAY);
    else if (state == WAIT)   dly_q <= dly_q - RD_DLY_W'(1);
  end

  // response capture and compare; gb_addr still holds this beat's address
  always_ff @(posedge gb_clk or negedge gb_rst_n) begin
    if (!gb_rst_n) begin
      rsp_rdata <= '0; rsp_addr <= '0; rsp_err <= 1'b0;
    end else if (cap) begin
      rsp_rdata <= gb_rdata;
      rsp_addr  <= gb_addr;
      rsp_err   <= check_q & (|((gb_rdata ^ (expect_q + DW'(k_q))) & mask_q));
    end
  end

  // sticky failure flag, clear wins
  always_ff @(posedge gb_clk or negedge gb_rst_n) begin
    if (!gb_rst_n)               fail <= 1'b0;
    else if (clr)                fail <= 1'b0;
    else if (hs_rsp && rsp_err)  fail <= 1'b1;
  end

  gb_sat_counter #(.W(CW), .SAT(1'b1)) u_err_cnt (
    .clk(gb_clk), .rst_n(gb_rst_n), .clr(clr),
    .inc(hs_rsp & rsp_err), .cnt(err_count)
  );

  gb_sat_counter #(.W(CW), .SAT(1'b0)) u_xact_cnt (
    .clk(gb_clk), .rst_n(gb_rst_n), .clr(clr),
    .inc((state == WR) | hs_rsp), .cnt(xact_count)
  );

endmodule

// File: tb/tb_gb_xact_engine.sv
// Directed bench: two engines (16-bit and 2-bit counters) share stimulus
// and a simple ghostbus slave with a READ_DELAY-deep read pipe.
module tb_gb_xact_engine;
  localparam int ADW = 24, DW = 32, RDLY = 3, BW = 8, CW = 16, CWS = 2;

  logic gb_clk = 1'b0, gb_rst_n = 1'b0;
  logic cmd_valid = 1'b0, cmd_write = 1'b0, cmd_check = 1'b0;
  logic rsp_ready = 1'b1, clr = 1'b0;
  logic [ADW-1:0] cmd_addr = '0;
  logic [DW-1:0]  cmd_wdata = '0, cmd_expect = '0, cmd_mask = '0;
  logic [BW-1:0]  cmd_len = '0;
  logic [DW-1:0]  gb_rdata;

  logic cmd_ready, rsp_valid, rsp_err, gb_wen, gb_rstb, busy, fail;
  logic [DW-1:0]  rsp_rdata, gb_wdata;
  logic [ADW-1:0] rsp_addr, gb_addr;
  logic [CW-1:0]  err_count, xact_count;

  logic s_cmd_ready, s_rsp_valid, s_rsp_err, s_gb_wen, s_gb_rstb, s_busy, s_fail;
  logic [DW-1:0]  s_rsp_rdata, s_gb_wdata;
  logic [ADW-1:0] s_rsp_addr, s_gb_addr;
  logic [CWS-1:0] s_err_count, s_xact_count;

  gb_xact_engine #(.ADW(ADW), .DW(DW), .READ_DELAY(RDLY), .BW(BW), .CW(CW)) dut (
    .gb_clk(gb_clk), .gb_rst_n(gb_rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_expect(cmd_expect),
    .cmd_mask(cmd_mask), .cmd_check(cmd_check), .cmd_len(cmd_len), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_addr(rsp_addr), .rsp_err(rsp_err),
    .gb_addr(gb_addr), .gb_wdata(gb_wdata), .gb_wen(gb_wen), .gb_rstb(gb_rstb),
    .gb_rdata(gb_rdata), .clr(clr), .busy(busy), .fail(fail),
    .err_count(err_count), .xact_count(xact_count));

  gb_xact_engine #(.ADW(ADW), .DW(DW), .READ_DELAY(RDLY), .BW(BW), .CW(CWS)) dut_s (
    .gb_clk(gb_clk), .gb_rst_n(gb_rst_n), .cmd_valid(cmd_valid), .cmd_ready(s_cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_expect(cmd_expect),
    .cmd_mask(cmd_mask), .cmd_check(cmd_check), .cmd_len(cmd_len), .rsp_valid(s_rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(s_rsp_rdata), .rsp_addr(s_rsp_addr), .rsp_err(s_rsp_err),
    .gb_addr(s_gb_addr), .gb_wdata(s_gb_wdata), .gb_wen(s_gb_wen), .gb_rstb(s_gb_rstb),
    .gb_rdata(gb_rdata), .clr(clr), .busy(s_busy), .fail(s_fail),
    .err_count(s_err_count), .xact_count(s_xact_count));

  always #5 gb_clk = ~gb_clk;

  int cyc = 0;
  always @(posedge gb_clk) cyc <= cyc + 1;

  // slave: unwritten locations read back their low address byte;
  // read data is valid only in the cycle READ_DELAY after the strobe
  logic [DW-1:0]   mem [0:255];
  logic [255:0]    wr_flag = '0;
  logic [RDLY-1:0] p_vld = '0;
  logic [7:0]      p_a [0:RDLY-1];
  always @(posedge gb_clk) begin
    if (gb_wen) begin
      mem[gb_addr[7:0]]     <= gb_wdata;
      wr_flag[gb_addr[7:0]] <= 1'b1;
    end
    p_vld   <= {p_vld[RDLY-2:0], gb_rstb};
    p_a[0]  <= gb_addr[7:0];
    for (int i = 1; i < RDLY; i++) p_a[i] <= p_a[i-1];
  end
  assign gb_rdata = !p_vld[RDLY-1] ? 32'hDEAD_BEEF :
                    (wr_flag[p_a[RDLY-1]] ? mem[p_a[RDLY-1]] : {24'h0, p_a[RDLY-1]});

  // bus/response event logs sampled mid-cycle
  typedef struct { int c; logic [ADW-1:0] a; logic [DW-1:0] d; logic e; } ev_t;
  ev_t wq[$], sq[$], rq[$];
  int both_hi = 0;
  always @(negedge gb_clk) begin
    if (gb_wen)                 wq.push_back('{cyc, gb_addr, gb_wdata, 1'b0});
    if (gb_rstb)                sq.push_back('{cyc, gb_addr, '0, 1'b0});
    if (rsp_valid && rsp_ready) rq.push_back('{cyc, rsp_addr, rsp_rdata, rsp_err});
    if (gb_wen && gb_rstb)      both_hi++;
  end

  int n_run = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic clrq();
    wq.delete(); sq.delete(); rq.delete();
  endtask

  task automatic send(input logic wr, input logic [ADW-1:0] a, input logic [DW-1:0] wd,
                      input logic [DW-1:0] ex, input logic [DW-1:0] mk, input logic ck,
                      input logic [BW-1:0] ln);
    int t = 0;
    @(negedge gb_clk);
    while (!cmd_ready && t < 200) begin @(negedge gb_clk); t++; end
    chk("cmd_ready_wait", cmd_ready, 1);
    cmd_write = wr; cmd_addr = a; cmd_wdata = wd; cmd_expect = ex;
    cmd_mask = mk; cmd_check = ck; cmd_len = ln; cmd_valid = 1'b1;
    @(posedge gb_clk); #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int t = 0;
    @(negedge gb_clk);
    while (busy && t < 500) begin @(negedge gb_clk); t++; end
    chk(tag, busy, 0);
  endtask

  logic [ADW-1:0] wa [4];
  logic [DW-1:0]  d0;
  logic [ADW-1:0] a0;
  logic           stable;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    wa = '{24'hFFFFFE, 24'hFFFFFF, 24'h000000, 24'h000001};

    // reset state
    repeat (3) @(negedge gb_clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_bus", {gb_wen, gb_rstb, gb_addr, gb_wdata}, 0);
    chk("rst_cnt", {fail, err_count, xact_count}, 0);
    gb_rst_n = 1'b1;

    // single read
    clrq();
    send(0, 24'h4, 0, 0, 0, 0, 0);
    wait_idle("rd1_idle");
    chk("rd1_nstb", sq.size(), 1);
    chk("rd1_nrsp", rq.size(), 1);
    if (sq.size() == 1 && rq.size() == 1) begin
      chk("rd1_lat", rq[0].c - sq[0].c, RDLY + 1);
      chk("rd1_data", rq[0].d, 32'h4);
      chk("rd1_addr", rq[0].a, 24'h4);
      chk("rd1_err", rq[0].e, 0);
    end
    chk("rd1_xact", xact_count, 1);
    @(negedge gb_clk); clr = 1'b1; @(negedge gb_clk); clr = 1'b0;
    chk("clr_xact", xact_count, 0);

    // write burst then checked read-back
    clrq();
    send(1, 24'h20, 32'hD0, 0, 0, 0, 7);
    wait_idle("wr_idle");
    chk("wr_nbeats", wq.size(), 8);
    for (int i = 0; i < wq.size(); i++) begin
      chk("wr_addr", wq[i].a, 24'h20 + i);
      chk("wr_data", wq[i].d, 32'hD0 + i);
      chk("wr_cyc", wq[i].c - wq[0].c, i);
    end
    clrq();
    send(0, 24'h20, 0, 32'hD0, 32'hFF, 1, 7);
    wait_idle("rdb_idle");
    chk("rdb_nrsp", rq.size(), 8);
    for (int i = 0; i < rq.size(); i++) begin
      chk("rdb_data", rq[i].d, 32'hD0 + i);
      chk("rdb_addr", rq[i].a, 24'h20 + i);
      chk("rdb_err", rq[i].e, 0);
      if (i > 0) chk("rdb_gap", rq[i].c - rq[i-1].c, RDLY + 2);
    end
    chk("rdb_xact", xact_count, 16);
    chk("rdb_xact_wrap", s_xact_count, 0);
    chk("rdb_fail", fail, 0);

    // compare mismatch, then masked-out mismatch
    clrq();
    send(0, 24'h1, 0, 32'h5, 32'hF, 1, 0);
    wait_idle("mm_idle");
    chk("mm_nrsp", rq.size(), 1);
    if (rq.size() == 1) begin
      chk("mm_err", rq[0].e, 1);
      chk("mm_data", rq[0].d, 32'h1);
    end
    chk("mm_fail", fail, 1);
    chk("mm_errcnt", err_count, 1);
    clrq();
    send(0, 24'h1, 0, 32'h5, 32'h0, 1, 0);
    wait_idle("mask_idle");
    if (rq.size() == 1) chk("mask_err", rq[0].e, 0);
    chk("mask_errcnt", err_count, 1);

    // backpressure on a two-beat read
    @(posedge gb_clk); #1 rsp_ready = 1'b0;
    clrq();
    send(0, 24'h10, 0, 0, 0, 0, 1);
    begin
      int t = 0;
      @(negedge gb_clk);
      while (!rsp_valid && t < 100) begin @(negedge gb_clk); t++; end
    end
    chk("bp_valid", rsp_valid, 1);
    d0 = rsp_rdata; a0 = rsp_addr; stable = 1'b1;
    repeat (10) begin
      @(negedge gb_clk);
      if (!rsp_valid || rsp_rdata !== d0 || rsp_addr !== a0) stable = 1'b0;
    end
    chk("bp_hold", stable, 1);
    chk("bp_data0", d0, 32'h10);
    chk("bp_nstb_held", sq.size(), 1);
    @(posedge gb_clk); #1 rsp_ready = 1'b1;
    wait_idle("bp_idle");
    chk("bp_nstb", sq.size(), 2);
    chk("bp_nrsp", rq.size(), 2);
    if (sq.size() == 2 && rq.size() == 2) begin
      chk("bp_restrobe", sq[1].c - rq[0].c, 1);
      chk("bp_data1", rq[1].d, 32'h11);
      chk("bp_addr1", rq[1].a, 24'h11);
    end

    // address wrap
    clrq();
    send(0, 24'hFFFFFE, 0, 0, 0, 0, 3);
    wait_idle("wrap_idle");
    chk("wrap_nrsp", rq.size(), 4);
    if (sq.size() == 4 && rq.size() == 4)
      for (int i = 0; i < 4; i++) begin
        chk("wrap_stb_addr", sq[i].a, wa[i]);
        chk("wrap_rsp_addr", rq[i].a, wa[i]);
        chk("wrap_data", rq[i].d, {24'h0, wa[i][7:0]});
      end

    // four more errors: 5 total, small counter saturates at 3
    clrq();
    send(0, 24'h1, 0, 32'h5, 32'hF, 1, 3);
    wait_idle("sat_idle");
    chk("sat_errcnt", err_count, 5);
    chk("sat_errcnt_s", s_err_count, 3);
    chk("sat_fail", fail, 1);

    // clear coincident with an erroring handshake
    @(posedge gb_clk); #1 rsp_ready = 1'b0;
    send(0, 24'h1, 0, 32'h5, 32'hF, 1, 0);
    begin
      int t = 0;
      @(negedge gb_clk);
      while (!rsp_valid && t < 100) begin @(negedge gb_clk); t++; end
    end
    chk("clr_rsp_err", rsp_err, 1);
    @(posedge gb_clk); #1 begin clr = 1'b1; rsp_ready = 1'b1; end
    @(posedge gb_clk); #1 clr = 1'b0;
    @(negedge gb_clk);
    chk("clr_errcnt", err_count, 0);
    chk("clr_errcnt_s", s_err_count, 0);
    chk("clr_fail", fail, 0);
    chk("clr_xact2", xact_count, 0);

    // reset during WAIT, then a fresh read
    clrq();
    send(0, 24'h30, 0, 0, 0, 0, 0);
    @(posedge gb_clk); #1 gb_rst_n = 1'b0;
    #1;
    chk("mrst_ready", cmd_ready, 1);
    chk("mrst_busy", busy, 0);
    chk("mrst_outs", {rsp_valid, gb_rstb, gb_wen, gb_addr, rsp_rdata}, 0);
    repeat (8) @(negedge gb_clk);
    chk("mrst_norsp", rq.size(), 0);
    gb_rst_n = 1'b1;
    clrq();
    send(0, 24'h30, 0, 32'h30, 32'hFF, 1, 0);
    wait_idle("post_idle");
    chk("post_nrsp", rq.size(), 1);
    if (rq.size() == 1) begin
      chk("post_data", rq[0].d, 32'h30);
      chk("post_err", rq[0].e, 0);
    end
    chk("post_xact", xact_count, 1);

    chk("wen_rstb_excl", both_hi, 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
